// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary counter: acceleration FSM states and
// the encoding used to carry the turning direction between blocks.
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAST  = 2'd2
  } accel_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotary_accel.sv
// Acceleration tracker for the rotary counter: a gap timer and a streak
// counter drive an IDLE/TRACK/FAST FSM that selects the step size for the
// current detent. Compiled into the top only with ROTARY_COUNTER_ACCEL_EN.
//
// Handshake: i_det is a one-cycle qualifier; i_dir is only meaningful while
// i_det is high. There is no back-pressure; every qualified detent is taken.
module rotary_accel
  import rotary_pkg::*;
#(
  parameter int ACCEL_WINDOW = 1000,
  parameter int ACCEL_COUNT  = 4,
  parameter int ACCEL_STEP   = 4,
  parameter int STEP_W       = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_det,
  input  logic              i_dir,
  input  logic              i_abort,
  output logic [STEP_W-1:0] o_step
);

  localparam int TW = $clog2(ACCEL_WINDOW + 1);
  localparam int SW = $clog2(ACCEL_COUNT + 1);

  accel_state_t  r_state;
  logic          r_dir;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_timer;

  logic w_fast_gap;
  logic w_same_dir;
  logic w_timeout;

  assign w_fast_gap = (r_timer < TW'(ACCEL_WINDOW));
  assign w_same_dir = (i_dir == r_dir);
  assign w_timeout  = (r_timer == TW'(ACCEL_WINDOW));

  // Step for the detent being applied this cycle: large only when already
  // FAST and still turning the same way; a reversal always steps by one.
  always_comb begin
    o_step = STEP_W'(1);
    if (r_state == FAST && w_same_dir) begin
      o_step = STEP_W'(ACCEL_STEP);
    end
  end

  // FSM, streak and gap timer; the timer saturates at the window length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_dir    <= DIR_LEFT;
      r_streak <= '0;
      r_timer  <= '0;
    end else if (i_abort) begin
      r_state  <= IDLE;
      r_streak <= '0;
      r_timer  <= '0;
    end else if (i_det) begin
      r_timer <= '0;
      r_dir   <= i_dir;
      if (r_state == IDLE) begin
        r_state  <= TRACK;
        r_streak <= SW'(1);
      end else if (w_same_dir && w_fast_gap) begin
        if (r_state == TRACK) begin
          if (int'(r_streak) + 1 >= ACCEL_COUNT) begin
            r_state  <= FAST;
            r_streak <= SW'(ACCEL_COUNT);
          end else begin
            r_streak <= r_streak + SW'(1);
          end
        end
      end else begin
        r_state  <= TRACK;
        r_streak <= SW'(1);
      end
    end else begin
      if (!w_timeout) begin
        r_timer <= r_timer + TW'(1);
      end
      if (r_state != IDLE && w_timeout) begin
        r_state  <= IDLE;
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/rotary_counter.sv
// Rotary position counter: detent pulses move a bounded position that
// either saturates or wraps, with synchronous clear and clamped load.
// Optional acceleration (larger steps on fast same-direction turning) is
// enabled by defining ROTARY_COUNTER_ACCEL_EN.
module rotary_counter
  import rotary_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_VALUE    = 0,
  parameter int MAX_VALUE    = 255,
  parameter int INIT_VALUE   = 0,
  parameter int WRAP         = 0,
  parameter int ACCEL_WINDOW = 1000,
  parameter int ACCEL_COUNT  = 4,
  parameter int ACCEL_STEP   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rotary_left,
  input  logic             rotary_right,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);

  // One extra bit so sums and differences never overflow before clamping.
  localparam int XW = WIDTH + 1;
  localparam logic [XW-1:0] MIN_X   = XW'(MIN_VALUE);
  localparam logic [XW-1:0] MAX_X   = XW'(MAX_VALUE);
  localparam logic [XW-1:0] INIT_X  = XW'(INIT_VALUE);
  localparam logic [XW-1:0] RANGE_X = XW'(MAX_VALUE - MIN_VALUE + 1);
  localparam logic [XW-1:0] ONE_X   = XW'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  logic             r_at_min;
  logic             r_at_max;

  logic          w_det;
  logic          w_dir;
  logic [XW-1:0] w_step;
  logic [XW-1:0] w_cur;
  logic [XW-1:0] w_ld;
  logic [XW-1:0] w_up;
  logic [XW-1:0] w_dn_lim;
  logic [XW-1:0] w_next;

  // A detent is exactly one of the two pulses; both together are ignored.
  assign w_det = rotary_left ^ rotary_right;
  assign w_dir = rotary_right ? DIR_RIGHT : DIR_LEFT;

`ifdef ROTARY_COUNTER_ACCEL_EN
  rotary_accel #(
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .ACCEL_COUNT  (ACCEL_COUNT),
    .ACCEL_STEP   (ACCEL_STEP),
    .STEP_W       (XW)
  ) u_accel (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_det   (w_det),
    .i_dir   (w_dir),
    .i_abort (clear | load),
    .o_step  (w_step)
  );
`else
  assign w_step = ONE_X;
`endif

  assign w_cur    = {1'b0, r_value};
  assign w_ld     = {1'b0, load_value};
  assign w_up     = w_cur + w_step;
  assign w_dn_lim = MIN_X + w_step;

  // Next position: clear beats load beats detent; out-of-range results
  // clamp or wrap modulo the range size.
  always_comb begin
    w_next = w_cur;
    if (clear) begin
      w_next = INIT_X;
    end else if (load) begin
      if (w_ld < MIN_X) begin
        w_next = MIN_X;
      end else if (w_ld > MAX_X) begin
        w_next = MAX_X;
      end else begin
        w_next = w_ld;
      end
    end else if (w_det) begin
      if (w_dir == DIR_RIGHT) begin
        if (w_up > MAX_X) begin
          w_next = (WRAP != 0) ? MIN_X + ((w_up - MAX_X - ONE_X) % RANGE_X) : MAX_X;
        end else begin
          w_next = w_up;
        end
      end else begin
        if (w_cur < w_dn_lim) begin
          w_next = (WRAP != 0) ? MAX_X - ((w_dn_lim - w_cur - ONE_X) % RANGE_X) : MIN_X;
        end else begin
          w_next = w_cur - w_step;
        end
      end
    end
  end

  // Position register with its change strobe and bound flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value   <= INIT_X[WIDTH-1:0];
      r_changed <= 1'b0;
      r_at_min  <= (INIT_X == MIN_X);
      r_at_max  <= (INIT_X == MAX_X);
    end else begin
      r_value   <= w_next[WIDTH-1:0];
      r_changed <= (w_next != w_cur);
      r_at_min  <= (w_next == MIN_X);
      r_at_max  <= (w_next == MAX_X);
    end
  end

  assign value   = r_value;
  assign changed = r_changed;
  assign at_min  = r_at_min;
  assign at_max  = r_at_max;

endmodule

// File: doc/rotary_counter.md
ROTARY_COUNTER -- requirements
Module: rotary_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the width of the position value.
REQ-002 The block SHALL have parameter MIN_VALUE, default 0, the lower bound of the position.
REQ-003 The block SHALL have parameter MAX_VALUE, default 255, the upper bound of the position (MIN_VALUE < MAX_VALUE < 2^WIDTH).
REQ-004 The block SHALL have parameter INIT_VALUE, default 0, the position after reset.
REQ-005 The block SHALL have parameter WRAP, default 0: 0 saturates at the bounds, 1 wraps around.
REQ-006 The block SHALL have parameter ACCEL_WINDOW, default 1000, the maximum cycle gap between detents that counts as fast turning.
REQ-007 The block SHALL have parameter ACCEL_COUNT, default 4, the number of consecutive fast same-direction detents that enters FAST.
REQ-008 The block SHALL have parameter ACCEL_STEP, default 4, the step size used in FAST.
REQ-009 Port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-010 Port reset, input, 1, asynchronous active-low reset.
REQ-011 Port rotary_left, input, 1, one-cycle detent pulse from the rotary interface; decrements the position.
REQ-012 Port rotary_right, input, 1, one-cycle detent pulse; increments the position.
REQ-013 Port clear, input, 1, synchronous return to INIT_VALUE.
REQ-014 Port load, input, 1, synchronous load of load_value.
REQ-015 Port load_value, input, WIDTH, value loaded; clamped to [MIN_VALUE, MAX_VALUE].
REQ-016 Port value, output, WIDTH, registered current position.
REQ-017 Port changed, output, 1, one-cycle strobe, high in the same cycle that value shows a new number.
REQ-018 Ports at_min and at_max, output, 1 each, registered flags: value equals MIN_VALUE or MAX_VALUE.

Function
REQ-019 The block SHALL sample a detent on a rising clock edge where exactly one of rotary_left/rotary_right is high; value SHALL update at that same edge (1-cycle latency from pulse to value).
REQ-020 When both rotary_left and rotary_right are high in one cycle, the block SHALL ignore them: no change to value, FSM or timer.
REQ-021 Priority SHALL be clear > load > detent; a detent coinciding with clear or load is discarded, and the FSM returns to IDLE.
REQ-022 Arithmetic SHALL use WIDTH+1 bits; with WRAP=0 a result beyond a bound clamps to that bound.
REQ-023 With WRAP=1 a step past MAX_VALUE SHALL continue from MIN_VALUE (and vice versa), modulo the range size (MAX_VALUE-MIN_VALUE+1).
REQ-024 changed SHALL assert only if the new value differs from the old; a detent at a saturated bound, or a clear/load to the current value, SHALL leave changed low.
REQ-025 The step SHALL be 1 in states IDLE and TRACK, and ACCEL_STEP in FAST.
REQ-026 FSM IDLE -> TRACK on any detent; streak counter = 1; gap timer restarts.
REQ-027 FSM TRACK: a same-direction detent with gap timer < ACCEL_WINDOW increments the streak; when the streak reaches ACCEL_COUNT, the FSM goes to FAST. The detent that reaches ACCEL_COUNT still uses step 1.
REQ-028 FSM TRACK/FAST: an opposite-direction detent goes to TRACK with streak 1; the step for that detent is 1.
REQ-029 FSM TRACK/FAST: gap timer reaching ACCEL_WINDOW with no detent goes to IDLE. The timer saturates and does not wrap.

Reset
REQ-030 While reset is low: value = INIT_VALUE, changed = 0, at_min/at_max reflect INIT_VALUE, FSM = IDLE, streak = 0, timer = 0.
REQ-031 Reset asserted mid-rotation SHALL discard any pending detent; the first detent after release is treated as from IDLE.

Configuration
REQ-032 Macro ROTARY_COUNTER_ACCEL_EN: when defined, the FSM, timer and streak logic of REQ-025..029 SHALL be compiled in.
REQ-033 When ROTARY_COUNTER_ACCEL_EN is undefined, the step SHALL always be 1, no timer or FSM registers SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-034 Shared package rotary_pkg SHALL hold the FSM state typedef (IDLE, TRACK, FAST) and the direction encoding constants (DIR_LEFT, DIR_RIGHT).
REQ-035 The acceleration FSM, timer and streak counter SHALL be sub-module rotary_accel, which outputs the step size; it is instantiated only under ROTARY_COUNTER_ACCEL_EN.

Verification
REQ-036 Reset low at t=1..5, INIT_VALUE=10 -> value=10, changed=0, at_min=0, at_max=0 during and after reset.
REQ-037 Defaults, WRAP=0, value=254, three rotary_right pulses 20 cycles apart -> value 255, 255, 255; changed high only on the first; at_max=1.
REQ-038 WRAP=1, value=0, one rotary_left -> value=255, changed=1 one cycle after the pulse.
REQ-039 ACCEL_EN, six rotary_right pulses 100 cycles apart from 0 -> values 1, 2, 3, 4, 8, 12. Then a 1200-cycle idle gap and one more pulse -> 13.
REQ-040 rotary_left and rotary_right both high for one cycle -> value unchanged, changed=0. A pulse coinciding with load=1, load_value=50 -> value=50.
